// File: rtl/h_bridge_motion_sequencer.sv
// H-bridge motion sequencer: accepts stop/forward/reverse commands, inserts a
// fixed dead time between motion states and refuses or aborts motion on obstacles.
module h_bridge_motion_sequencer #(
  parameter logic [3:0]  FORWARD_PATTERN = 4'b0110,
  parameter logic [3:0]  REVERSE_PATTERN = 4'b1001,
  parameter logic [15:0] DEAD_CYCLES     = 16'd50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  input  logic [7:0] sensIP,
  input  logic [1:0] sensIR_frontBack,
  output logic [3:0] movingDirection_finalDecision,
  output logic [1:0] isMoving_isItForward,
  output logic       blocked
);

  typedef enum logic [1:0] {STOP, FWD, REV, DEAD} stateT;

  localparam logic [15:0] LAST_COUNT = DEAD_CYCLES - 16'd1;

  stateT       state;
  stateT       target;
  logic [15:0] deadCount;
  logic [9:0]  sensMeta;
  logic [9:0]  sensSync;
  logic        frontObst;
  logic        backObst;
  logic        accept;

  // Sensor vector layout: [7:0] proximity, [8] IR front, [9] IR back.
  assign frontObst = (|sensSync[3:0]) | sensSync[8];
  assign backObst  = (|sensSync[7:4]) | sensSync[9];
  assign accept    = cmd_valid & cmd_ready;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    cmd_ready = 1'b0;
    case (state)
      STOP:    cmd_ready = 1'b1;
      FWD:     cmd_ready = ~frontObst;
      REV:     cmd_ready = ~backObst;
      default: cmd_ready = 1'b0;
    endcase
  end

  always_comb begin
    movingDirection_finalDecision = 4'b0000;
    isMoving_isItForward          = 2'b00;
    case (state)
      FWD: begin
        movingDirection_finalDecision = FORWARD_PATTERN;
        isMoving_isItForward          = 2'b11;
      end
      REV: begin
        movingDirection_finalDecision = REVERSE_PATTERN;
        isMoving_isItForward          = 2'b01;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= STOP;
      target    <= STOP;
      deadCount <= 16'd0;
      blocked   <= 1'b0;
      sensMeta  <= 10'd0;
      sensSync  <= 10'd0;
    end else begin
      sensMeta <= {sensIR_frontBack, sensIP};
      sensSync <= sensMeta;
      case (state)
        STOP: begin
          if (accept) begin
            case (cmd)
              2'b01: begin
                if (frontObst) blocked <= 1'b1;
                else begin
                  state   <= FWD;
                  blocked <= 1'b0;
                end
              end
              2'b10: begin
                if (backObst) blocked <= 1'b1;
                else begin
                  state   <= REV;
                  blocked <= 1'b0;
                end
              end
              default: blocked <= 1'b0;
            endcase
          end
        end
        FWD: begin
          if (frontObst) begin
            state     <= DEAD;
            target    <= STOP;
            deadCount <= 16'd0;
            blocked   <= 1'b1;
          end else if (accept) begin
            case (cmd)
              2'b01: blocked <= 1'b0;
              2'b10: begin
                state     <= DEAD;
                target    <= REV;
                deadCount <= 16'd0;
              end
              default: begin
                state     <= DEAD;
                target    <= STOP;
                deadCount <= 16'd0;
              end
            endcase
          end
        end
        REV: begin
          if (backObst) begin
            state     <= DEAD;
            target    <= STOP;
            deadCount <= 16'd0;
            blocked   <= 1'b1;
          end else if (accept) begin
            case (cmd)
              2'b10: blocked <= 1'b0;
              2'b01: begin
                state     <= DEAD;
                target    <= FWD;
                deadCount <= 16'd0;
              end
              default: begin
                state     <= DEAD;
                target    <= STOP;
                deadCount <= 16'd0;
              end
            endcase
          end
        end
        default: begin
          // Obstacles are only looked at on the exit edge, never to cut DEAD short.
          if (deadCount == LAST_COUNT) begin
            case (target)
              FWD: begin
                if (frontObst) begin
                  state   <= STOP;
                  blocked <= 1'b1;
                end else state <= FWD;
              end
              REV: begin
                if (backObst) begin
                  state   <= STOP;
                  blocked <= 1'b1;
                end else state <= REV;
              end
              default: state <= STOP;
            endcase
            target <= STOP;
          end else begin
            deadCount <= deadCount + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/h_bridge_motion_sequencer.md
H_BRIDGE_MOTION_SEQUENCER -- requirements
Module: h_bridge_motion_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- FORWARD_PATTERN, 4'b0110, H-bridge IN pattern for forward motion.
- REVERSE_PATTERN, 4'b1001, H-bridge IN pattern for reverse motion.
- DEAD_CYCLES, 16'd50000, brake/dead-time length in clocks; legal range 1..65535.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock, in, 1, sole clock; all logic on rising edge.
- reset, in, 1, asynchronous active-high reset.
- cmd_valid, in, 1, command offered.
- cmd, in, 2, motion command: 00 stop, 01 forward, 10 reverse, 11 treated as stop.
- cmd_ready, out, 1, sequencer can accept a command.
- sensIP, in, 8, proximity sensors, active-high obstacle; [3:0] front, [7:4] back.
- sensIR_frontBack, in, 2, IR obstacle, active-high; [0] front, [1] back.
- movingDirection_finalDecision, out, 4, H-bridge IN drive pattern.
- isMoving_isItForward, out, 2, [0] motor driven, [1] direction is forward.
- blocked, out, 1, last requested motion was refused or aborted by an obstacle.

Function
REQ-003 All sensor inputs SHALL pass through a 2-flop synchronizer before use; front_obst = OR(sync sensIP[3:0], sync sensIR_frontBack[0]); back_obst = OR(sync sensIP[7:4], sync sensIR_frontBack[1]).
REQ-004 FSM states SHALL be STOP, FWD, REV, DEAD; the target register SHALL hold STOP, FWD or REV.
REQ-005 A command SHALL be accepted only on a rising edge where cmd_valid=1 and cmd_ready=1.
REQ-006 cmd_ready SHALL be 1 in STOP, FWD and REV, and 0 in DEAD.
REQ-007 Outputs SHALL be Moore, decoded from the state register, so that a state entered at edge N drives outputs from edge N on.
- STOP, DEAD: 4'b0000 and isMoving_isItForward=2'b00.
- FWD: FORWARD_PATTERN and 2'b11.
- REV: REVERSE_PATTERN and 2'b01.
REQ-008 STOP SHALL respond as follows.
- Accepted forward with front_obst=0 -> FWD, blocked<=0.
- Accepted forward with front_obst=1 -> remain STOP, blocked<=1.
- Reverse SHALL behave symmetrically using back_obst.
- Accepted stop -> remain STOP, blocked<=0.
REQ-009 FWD SHALL respond as follows.
- front_obst=1 -> DEAD, target<=STOP, blocked<=1; the obstacle SHALL win over any command offered in the same cycle, and that command SHALL NOT be accepted (cmd_ready forced 0 that cycle).
- Otherwise, accepted reverse -> DEAD, target<=REV.
- Otherwise, accepted stop -> DEAD, target<=STOP.
- Otherwise, accepted forward -> no state change, blocked<=0.
REQ-010 REV SHALL mirror REQ-009, using back_obst and swapping FWD/REV.
REQ-011 On entering DEAD the dead counter SHALL clear to 0, then increment each clock.
REQ-012 When the counter equals DEAD_CYCLES-1, DEAD SHALL exit on the next edge.
- Target STOP -> STOP.
- Target FWD with front_obst=0 -> FWD.
- Target FWD with front_obst=1 -> STOP, blocked<=1.
- Target REV SHALL behave symmetrically using back_obst.
REQ-013 The motor SHALL be undriven (4'b0000) for exactly DEAD_CYCLES clocks between any motion state and any other state.
REQ-014 No path FWD->REV or REV->FWD SHALL bypass DEAD.
REQ-015 The dead counter SHALL be 16 bits and SHALL NOT wrap while in DEAD.
REQ-016 Obstacle changes during DEAD SHALL NOT shorten or extend DEAD; they are evaluated only at exit.

Reset
REQ-017 reset=1 SHALL immediately, without a clock edge, force the following state.
- State STOP; target STOP.
- Dead counter 0; blocked 0.
- movingDirection_finalDecision 4'b0000; isMoving_isItForward 2'b00; cmd_ready 1.
- Synchronizer flops 0.
REQ-018 Reset asserted mid-DEAD or mid-motion SHALL abandon the pending target; after reset deasserts the block SHALL be in STOP and wait for a new command.

Verification (DEAD_CYCLES=4, sensors clear unless stated)
REQ-019 Reset, then accept cmd=01 -> movingDirection_finalDecision=0110, isMoving_isItForward=11 from the accepting edge, blocked=0.
REQ-020 In FWD, accept cmd=10 -> exactly 4 clocks of 0000 with cmd_ready=0, then 1001 with isMoving_isItForward=01.
REQ-021 In FWD, set sensIP[2]=1 -> after 2 sync clocks enter DEAD, 4 clocks of 0000, then STOP with blocked=1; a cmd=01 offered in the obstacle cycle is not accepted.
REQ-022 In STOP with sensIR_frontBack[1]=1, offer cmd=10 -> stays 0000, blocked=1; then offer cmd=01 -> 0110, blocked=0.
REQ-023 In REV, accept cmd=01 and raise sensIP[0] during DEAD -> DEAD lasts 4 clocks, then STOP with blocked=1.
REQ-024 Assert reset on the 2nd DEAD clock of a REV->FWD change -> outputs 0000 immediately; after release, state STOP with no FWD entry.
